// File: rtl/soc_decerr_slave.sv
// soc_decerr_slave: AXI4 default slave answering every unmapped access with DECERR,
// plus a saturating fault counter and last-fault address capture for debug.
module soc_decerr_slave #(
    parameter int unsigned       IdWidth   = 5,
    parameter int unsigned       DataWidth = 64,
    parameter logic [DataWidth-1:0] RespData = 64'hDEAD_BEEF_DEAD_BEEF,
    parameter int unsigned       CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [63:0]          aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [63:0]          ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    input  logic                 err_clear_i,
    output logic [CntWidth-1:0]  err_count_o,
    output logic [63:0]          err_addr_o,
    output logic                 err_valid_o
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t wstate_q, wstate_d;
    rstate_t rstate_q, rstate_d;
    logic [IdWidth-1:0]  b_id_q, r_id_q;
    logic [7:0]          r_len_q, r_cnt_q;
    logic [CntWidth-1:0] cnt_q, cnt_d, cnt_base;
    logic [CntWidth:0]   cnt_sum;
    logic [63:0]         addr_q, addr_d;
    logic                valid_q, valid_d, aw_hs, ar_hs, r_hs;
    logic [1:0]          inc;

    assign aw_ready_o  = wstate_q == W_IDLE;
    assign w_ready_o   = wstate_q == W_DATA;
    assign b_valid_o   = wstate_q == W_RESP;
    assign b_id_o      = b_id_q;
    assign b_resp_o    = 2'b11;
    assign ar_ready_o  = rstate_q == R_IDLE;
    assign r_valid_o   = rstate_q == R_DATA;
    assign r_last_o    = r_valid_o && (r_cnt_q == r_len_q);
    assign r_id_o      = r_id_q;
    assign r_data_o    = RespData;
    assign r_resp_o    = 2'b11;
    assign err_count_o = cnt_q;
    assign err_addr_o  = addr_q;
    assign err_valid_o = valid_q;

    assign aw_hs = aw_valid_i && aw_ready_o;
    assign ar_hs = ar_valid_i && ar_ready_o;
    assign r_hs  = r_valid_o && r_ready_i;

    always_comb begin
        wstate_d = wstate_q;
        rstate_d = rstate_q;
        case (wstate_q)
            W_IDLE:  wstate_d = aw_valid_i ? W_DATA : W_IDLE;
            W_DATA:  wstate_d = (w_valid_i && w_last_i) ? W_RESP : W_DATA;
            W_RESP:  wstate_d = b_ready_i ? W_IDLE : W_RESP;
            default: wstate_d = W_IDLE;
        endcase
        rstate_d = (rstate_q == R_IDLE) ? (ar_valid_i ? R_DATA : R_IDLE)
                                        : ((r_ready_i && r_last_o) ? R_IDLE : R_DATA);
    end

    // A fault in the same cycle as a clear still counts, starting from zero.
    always_comb begin
        inc      = {1'b0, aw_hs} + {1'b0, ar_hs};
        cnt_base = err_clear_i ? '0 : cnt_q;
        cnt_sum  = {1'b0, cnt_base} + {{(CntWidth-1){1'b0}}, inc};
        cnt_d    = cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
        valid_d  = (valid_q && !err_clear_i) || aw_hs || ar_hs;
        addr_d   = aw_hs ? aw_addr_i : ar_hs ? ar_addr_i : addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            b_id_q   <= '0;
            r_id_q   <= '0;
            r_len_q  <= '0;
            r_cnt_q  <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            if (aw_hs) b_id_q <= aw_id_i;
            if (ar_hs) begin
                r_id_q  <= ar_id_i;
                r_len_q <= ar_len_i;
                r_cnt_q <= '0;
            end else if (r_hs) begin
                r_cnt_q <= r_cnt_q + 8'd1;
            end
        end
    end
endmodule
